imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, is the immediate output width; legal values are 32 and 64.
REQ-002 Parameter CNT_W, default 16, is the width of the illegal-opcode counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the instruction is presented.
REQ-006 in_ready  output  1  the block accepts the instruction this cycle; driven directly from a register.
REQ-007 instruction  input  32  raw RV instruction word.
REQ-008 out_valid  output  1  the result is presented.
REQ-009 out_ready  input  1  the consumer accepts the result.
REQ-010 imm_data  output  XLEN  sign- or zero-extended immediate.
REQ-011 imm_type  output  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 7=NONE.
REQ-012 illegal  output  1  the opcode has no immediate format.
REQ-013 illegal_count  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-014 An input transfer occurs when in_valid and in_ready are both 1; an output transfer occurs when out_valid and out_ready are both 1.
REQ-015 Opcode [6:0] decode:
- 0000011, 1100111 -> I
- 0010011 -> I, or SHAMT when funct3 is 001 or 101
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- all others -> NONE with illegal=1.
REQ-016 Immediate bit fields:
- I = [31:20]
- S = {[31:25],[11:7]}
- B = {[31],[7],[30:25],[11:8],0}
- U = {[31:12],12'b0}
- J = {[31],[19:12],[20],[30:21],0}
REQ-017 I, S, B, U and J immediates are sign-extended from instruction[31] to XLEN.
REQ-018 The SHAMT immediate is zero-extended:
- XLEN=64: from [25:20].
- XLEN=32: from [24:20].
REQ-019 For NONE, imm_data is 0.
REQ-020 Latency: an instruction accepted in cycle N is presented on the outputs no earlier than cycle N+1, and in order.
REQ-021 Buffering is a two-entry skid structure: a main output register plus one skid register.
REQ-022 The state machine has three states:
- EMPTY: no entry held.
- ONE: main register valid.
- TWO: main and skid registers valid.
REQ-023 EMPTY transitions:
- Input transfer -> ONE.
- Otherwise stay in EMPTY.
REQ-024 ONE transitions:
- Input and output transfer together -> stay in ONE; main reloads with the new result.
- Input transfer only -> TWO; the new result goes to skid.
- Output transfer only -> EMPTY.
REQ-025 TWO transitions:
- Output transfer -> ONE; skid moves to main.
- Input is not accepted in TWO.
REQ-026 in_ready is 1 in EMPTY and ONE and 0 in TWO, computed as the registered next-state value.
REQ-027 out_valid is 1 in ONE and TWO.
REQ-028 The outputs imm_data, imm_type and illegal always reflect the main register, and hold stable while out_valid=1 and out_ready=0.
REQ-029 illegal_count increments by 1 on each input transfer with illegal=1, saturates at all-ones, and never wraps.
REQ-030 in_valid without in_ready has no effect, including on illegal_count.

Reset
REQ-031 While reset=1, the block enters EMPTY and holds these values:
- out_valid=0, in_ready=0.
- imm_data=0, imm_type=7, illegal=0, illegal_count=0.
REQ-032 The cycle after reset deasserts, in_ready=1.
REQ-033 Reset asserted mid-operation discards both held entries with no output transfer.

Structure
REQ-034 Package imm_pkg holds:
- opcode constants.
- imm_type codes.
- the state encoding.
REQ-035 The combinational decode and extension logic sits in one sub-module, imm_decode, parametrised by XLEN.
REQ-036 imm_gen_pipe holds only the two data registers, the state machine and the counter.

Verification
REQ-037 With out_ready=1, input 0xFFF00093 (addi, imm -1) -> next cycle imm_data all-ones, imm_type=0, illegal=0.
REQ-038 Input 0xFE000EE3 (beq, offset -4) -> imm_data = -4 sign-extended, imm_type=2.
REQ-039 Hold out_ready=0 and offer three instructions back-to-back -> two are accepted, in_ready=0 from the cycle after the second is accepted, and releasing out_ready drains both in order.
REQ-040 XLEN=64, input 0x03F01013 (slli shamt 63) -> imm_data=63 zero-extended, imm_type=5.
REQ-041 Feed 2^CNT_W+3 inputs of 0x00000000 (illegal) -> illegal_count saturates at all-ones, and a reset mid-stream returns it to 0 with out_valid=0.

Source files
------------

// File: rtl/imm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_pkg : opcodes, immediate format codes and skid-buffer states     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_NONE  = 3'd7
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_decode : combinational RV immediate extraction and extension     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm_data,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic [XLEN-1:0]   shamt_ext;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign imm_i  = instruction[31:20];
  assign imm_s  = {instruction[31:25], instruction[11:7]};
  assign imm_b  = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u  = {instruction[31:12], 12'b0};
  assign imm_j  = {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

  // RV64 shifts carry a 6-bit shamt, RV32 only 5 bits.
  generate
    if (XLEN == 64) begin : g_shamt64
      assign shamt_ext = {{(XLEN-6){1'b0}}, instruction[25:20]};
    end else begin : g_shamt32
      assign shamt_ext = {{(XLEN-5){1'b0}}, instruction[24:20]};
    end
  endgenerate

  always_comb begin
    imm_data = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        imm_data = XLEN'(imm_i);
        imm_type = IMM_I;
      end
      OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          imm_data = shamt_ext;
          imm_type = IMM_SHAMT;
        end else begin
          imm_data = XLEN'(imm_i);
          imm_type = IMM_I;
        end
      end
      OP_STORE: begin
        imm_data = XLEN'(imm_s);
        imm_type = IMM_S;
      end
      OP_BRANCH: begin
        imm_data = XLEN'(imm_b);
        imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm_data = XLEN'(imm_u);
        imm_type = IMM_U;
      end
      OP_JAL: begin
        imm_data = XLEN'(imm_j);
        imm_type = IMM_J;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pipe : immediate generator behind a two-entry skid buffer    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_data,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{imm: '0, typ: IMM_NONE, ill: 1'b0};

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;
  entry_t          dec_entry;

  state_e          state_q, state_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_fire;
  logic            out_fire;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instruction(instruction),
    .imm_data   (dec_imm),
    .imm_type   (dec_type),
    .illegal    (dec_ill)
  );

  assign dec_entry = '{imm: dec_imm, typ: dec_type, ill: dec_ill};
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = dec_entry;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = dec_entry;
        end else if (in_fire) begin
          state_d = ST_TWO;
          skid_d  = dec_entry;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (in_fire && dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Handshake flags follow the next state so they are plain flop outputs.
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_ENTRY;
      skid_q      <= RESET_ENTRY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign imm_data      = main_q.imm;
  assign imm_type      = main_q.typ;
  assign illegal       = main_q.ill;
  assign illegal_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imm_gen_pipe : directed bench with an in-order reference model    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imm_gen_pipe;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_data;
  logic [2:0]       imm_type;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   cnt_model;
  int   errors;
  int   checks;
  int   or_mode;
  logic rst_s;

  imm_gen_pipe #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instruction  (instruction),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .imm_data     (imm_data),
    .imm_type     (imm_type),
    .illegal      (illegal),
    .illegal_count(illegal_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: immediate value computed as a signed integer from the field rules.
  function automatic exp_t model(input logic [31:0] x);
    exp_t r;
    logic signed [12:0] b;
    logic signed [20:0] j;
    r.imm = 64'd0;
    r.typ = 3'd7;
    r.ill = 1'b0;
    b = {x[31], x[7], x[30:25], x[11:8], 1'b0};
    j = {x[31], x[19:12], x[20], x[30:21], 1'b0};
    case (x[6:0])
      7'h03, 7'h67: begin r.typ = 3'd0; r.imm = longint'($signed(x[31:20])); end
      7'h13: begin
        if (x[14:12] == 3'd1 || x[14:12] == 3'd5) begin
          r.typ = 3'd5; r.imm = 64'(x[25:20]);
        end else begin
          r.typ = 3'd0; r.imm = longint'($signed(x[31:20]));
        end
      end
      7'h23: begin r.typ = 3'd1; r.imm = longint'($signed({x[31:25], x[11:7]})); end
      7'h63: begin r.typ = 3'd2; r.imm = longint'(b); end
      7'h37, 7'h17: begin r.typ = 3'd3; r.imm = longint'($signed({x[31:12], 12'h000})); end
      7'h6F: begin r.typ = 3'd4; r.imm = longint'(j); end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  initial begin
    rst_s = 1'b1;
    forever begin
      @(posedge clk);
      rst_s = reset;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every cycle checks handshake, counter and the head entry.
  initial begin
    bit in_f;
    bit out_f;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_imm_data", imm_data, 64'd0);
        chk("rst_imm_type", 64'(imm_type), 64'd7);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_count", 64'(illegal_count), 64'd0);
        q.delete();
        cnt_model = 0;
      end else begin
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("illegal_count", 64'(illegal_count), 64'(cnt_model));
        if (out_valid && q.size() > 0) begin
          chk("imm_data", imm_data, q[0].imm);
          chk("imm_type", 64'(imm_type), 64'(q[0].typ));
          chk("illegal", 64'(illegal), 64'(q[0].ill));
        end
      end
      in_f  = in_valid && in_ready && !reset;
      out_f = out_valid && out_ready && !reset;
      if (out_f && q.size() > 0) void'(q.pop_front());
      if (in_f) begin
        e = model(instruction);
        q.push_back(e);
        if (e.ill && cnt_model < (1 << CNT_W) - 1) cnt_model++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] x);
    bit done;
    in_valid    = 1'b1;
    instruction = x;
    done        = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = in_ready && !reset;
      tick();
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic literal(input string name, input logic [63:0] imm_e, input logic [2:0] typ_e);
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_imm"}, imm_data, imm_e);
    chk({name, "_type"}, 64'(imm_type), 64'(typ_e));
    chk({name, "_ill"}, 64'(illegal), 64'd0);
    tick();
  endtask

  logic [31:0] vec [12] = '{
    32'h0080_2103, 32'hFFC0_8067, 32'h00A1_2623, 32'h8000_0537,
    32'h0000_1097, 32'h7FE0_00EF, 32'h8000_006F, 32'h4030_D093,
    32'h00F1_1093, 32'h0000_0033, 32'h8000_0FE3, 32'hFE11_2E23
  };

  initial begin
    exp_t m;
    errors      = 0;
    checks      = 0;
    cnt_model   = 0;
    or_mode     = 1;
    reset       = 1'b1;
    in_valid    = 1'b0;
    instruction = 32'd0;

    m = model(32'hFE00_0EE3);
    chk("model_beq", m.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    m = model(32'h03F0_1013);
    chk("model_slli", m.imm, 64'd63);
    chk("model_slli_type", 64'(m.typ), 64'd5);
    m = model(32'h1234_50B7);
    chk("model_lui", m.imm, 64'h0000_0000_1234_5000);
    m = model(32'h8000_006F);
    chk("model_jal", m.imm, 64'hFFFF_FFFF_FFF0_0000);
    m = model(32'h0000_0000);
    chk("model_none_ill", 64'(m.ill), 64'd1);

    idle(3);
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    tick();

    send(32'hFFF0_0093);
    in_valid = 1'b0;
    literal("addi", 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
    send(32'hFE00_0EE3);
    in_valid = 1'b0;
    literal("beq", 64'hFFFF_FFFF_FFFF_FFFC, 3'd2);
    send(32'h03F0_1013);
    in_valid = 1'b0;
    literal("slli", 64'd63, 3'd5);

    or_mode = 2;
    for (int i = 0; i < 12; i++) send(vec[i]);
    in_valid = 1'b0;
    or_mode  = 1;
    idle(6);

    // Stall the consumer and offer three back-to-back instructions.
    or_mode = 0;
    idle(3);
    in_valid    = 1'b1;
    instruction = 32'h0010_0093;
    @(negedge clk);
    chk("bp_first_ready", 64'(in_ready), 64'd1);
    tick();
    instruction = 32'h0020_0093;
    @(negedge clk);
    chk("bp_second_ready", 64'(in_ready), 64'd1);
    tick();
    instruction = 32'h0030_0093;
    @(negedge clk);
    chk("bp_third_ready", 64'(in_ready), 64'd0);
    chk("bp_head", imm_data, 64'd1);
    tick();
    @(negedge clk);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_head_hold", imm_data, 64'd1);
    tick();
    in_valid = 1'b0;
    or_mode  = 1;
    idle(5);

    for (int i = 0; i < (1 << CNT_W) + 3; i++) send(32'h0000_0000);
    @(negedge clk);
    chk("count_saturated", 64'(illegal_count), 64'(4'hF));
    tick();
    or_mode = 0;
    idle(4);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_count", 64'(illegal_count), 64'd0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    or_mode  = 1;
    idle(4);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
